// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Summary  : Sequential instruction prefetcher with a DEPTH-entry {pc, instr}
//             FIFO towards decode; a redirect flushes queued and in-flight work.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h01000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              imem_address,
  output logic                     imem_enable,
  input  logic [31:0]              imem_data,
  input  logic                     d_ready,
  output logic                     d_valid,
  output logic [31:0]              d_pc,
  output logic [31:0]              d_instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [31:0]        c_nop     = 32'h00000013;
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w:0]   c_depth   = (c_cnt_w + 1)'(DEPTH);

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_pending_pc;
  logic               r_pending;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [31:0]        r_pc_mem    [DEPTH];
  logic [31:0]        r_instr_mem [DEPTH];

  logic [c_cnt_w:0]   w_occupancy;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;

  // The in-flight fetch reserves a slot so its response always finds room.
  assign w_occupancy = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_pending};
  assign w_issue     = !reset && !flush && (w_occupancy < c_depth);
  assign w_empty     = (r_count == '0);
  assign w_push      = r_pending && !flush && !reset;
  assign w_pop       = d_valid && d_ready;

  assign imem_enable   = w_issue;
  assign imem_address  = r_fetch_pc;
  assign d_valid       = !w_empty && !flush && !reset;
  assign d_pc          = (w_empty || reset) ? 32'h0 : r_pc_mem[r_rd_ptr];
  assign d_instruction = (w_empty || reset) ? c_nop : r_instr_mem[r_rd_ptr];
  assign count         = reset ? '0 : r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_pending    <= 1'b0;
      r_pending_pc <= 32'h0;
    end else if (flush) begin
      r_fetch_pc   <= redirect_pc;
      r_pending    <= 1'b0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_fetch_pc   <= r_fetch_pc + 32'd4;
        r_pending_pc <= r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable once counted valid.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_pending_pc;
      r_instr_mem[r_wr_ptr] <= imem_data;
    end
  end

endmodule
`default_nettype wire
